// File: rtl/shift_pkg.sv
// Shared types for the multi-pass shift arbiter.
// Holds op and FSM encodings plus the datapath width.
package shift_pkg;

    localparam int W  = 32;
    localparam int SW = 5;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_ROTL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_PASS1 = 2'b01,
        S_PASS2 = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    function automatic logic [W-1:0] bitrev(input logic [W-1:0] x);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = x[W-1-i];
        return r;
    endfunction

endpackage

// File: rtl/shift_rr_arb.sv
// Two-way grant: fixed priority to 0 or round-robin.
// Pointer remembers the last granted requester.
module shift_rr_arb
    import shift_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic last;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (RR_EN && !last) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Reset to "1 granted last" so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            last <= 1'b1;
        else if (|gnt)
            last <= gnt[1];
    end

endmodule

// File: rtl/shift_arbiter.sv
// Two requesters share one left shifter; right shifts and
// rotates are built from one or two bit-reversed passes.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [W-1:0]  req0_a,
    input  logic [W-1:0]  req1_a,
    input  logic [SW-1:0] req0_shamt,
    input  logic [SW-1:0] req1_shamt,
    input  logic [1:0]    req0_op,
    input  logic [1:0]    req1_op,
    output logic [W-1:0]  sh_a,
    output logic [W-1:0]  sh_b,
    input  logic [W-1:0]  sh_out,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [W-1:0]  rsp_data,
    output logic          rsp_id
);

    state_e        state, nxt;
    logic [1:0]    gnt, xfer;
    logic [W-1:0]  a_q, res_q, res_nxt;
    logic [SW-1:0] shamt_q;
    op_e           op_q;
    logic          id_q;
    logic          rev, sra, two;

    shift_rr_arb #(.RR_EN(RR_EN)) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req_valid),
        .en    (state == S_IDLE && reset),
        .gnt   (gnt)
    );

    assign req_ready = gnt;
    assign xfer      = req_valid & gnt;

    assign rev = (op_q == OP_SRL) || (op_q == OP_SRA);
    assign sra = (op_q == OP_SRA);
    // A zero shift never needs a second pass.
    assign two = (shamt_q != '0) &&
                 ((sra && a_q[W-1]) || op_q == OP_ROTL);

    always_comb begin
        nxt     = state;
        sh_a    = '0;
        sh_b    = '0;
        res_nxt = res_q;
        unique case (state)
            S_IDLE: begin
                if (|xfer) nxt = S_PASS1;
            end
            S_PASS1: begin
                sh_a    = rev ? bitrev(a_q) : a_q;
                sh_b    = {{(W-SW){1'b0}}, shamt_q};
                res_nxt = rev ? bitrev(sh_out) : sh_out;
                nxt     = two ? S_PASS2 : S_DONE;
            end
            S_PASS2: begin
                if (sra) begin
                    sh_a    = '1;
                    sh_b    = {{(W-SW){1'b0}}, shamt_q};
                    res_nxt = res_q | ~bitrev(sh_out);
                end else begin
                    sh_a    = bitrev(a_q);
                    sh_b    = {{(W-SW){1'b0}}, 5'd0 - shamt_q};
                    res_nxt = res_q | bitrev(sh_out);
                end
                nxt = S_DONE;
            end
            S_DONE: begin
                if (rsp_ready) nxt = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            a_q     <= '0;
            shamt_q <= '0;
            op_q    <= OP_SLL;
            id_q    <= 1'b0;
            res_q   <= '0;
        end else begin
            state <= nxt;
            res_q <= res_nxt;
            if (|xfer) begin
                id_q    <= xfer[1];
                a_q     <= xfer[1] ? req1_a : req0_a;
                shamt_q <= xfer[1] ? req1_shamt : req0_shamt;
                op_q    <= op_e'(xfer[1] ? req1_op : req0_op);
            end
        end
    end

    assign rsp_valid = (state == S_DONE);
    assign rsp_data  = res_q;
    assign rsp_id    = id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed and random checks of shift_arbiter against a
// plain-arithmetic shift model and a tie-break model.
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [31:0] a0 = '0, a1 = '0;
    logic [4:0]  s0 = '0, s1 = '0;
    logic [1:0]  op0 = '0, op1 = '0;
    logic        rsp_ready = 1'b0;

    logic [1:0]  req_ready, fp_ready;
    logic [31:0] sh_a, sh_b, sh_out;
    logic [31:0] fp_sh_a, fp_sh_b, fp_sh_out;
    logic        rsp_valid, rsp_id, fp_valid, fp_id;
    logic [31:0] rsp_data, fp_data;

    int checks = 0;
    int errors = 0;
    int last_id = 1;

    always #5 clk = ~clk;

    assign sh_out    = sh_a << sh_b;
    assign fp_sh_out = fp_sh_a << fp_sh_b;

    shift_arbiter #(.RR_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid),
        .req_ready(req_ready), .req0_a(a0), .req1_a(a1),
        .req0_shamt(s0), .req1_shamt(s1), .req0_op(op0),
        .req1_op(op1), .sh_a(sh_a), .sh_b(sh_b), .sh_out(sh_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id)
    );

    shift_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .reset(reset), .req_valid(req_valid),
        .req_ready(fp_ready), .req0_a(a0), .req1_a(a1),
        .req0_shamt(s0), .req1_shamt(s1), .req0_op(op0),
        .req1_op(op1), .sh_a(fp_sh_a), .sh_b(fp_sh_b),
        .sh_out(fp_sh_out), .rsp_valid(fp_valid),
        .rsp_ready(rsp_ready), .rsp_data(fp_data), .rsp_id(fp_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] a,
                                              input logic [4:0] s,
                                              input logic [1:0] op);
        case (op)
            2'b00:   return a << s;
            2'b01:   return a >> s;
            2'b10:   return $unsigned($signed(a) >>> s);
            default: return (s == 0) ? a : ((a << s) | (a >> (32 - s)));
        endcase
    endfunction

    function automatic int ref_lat(input logic [31:0] a,
                                   input logic [4:0] s,
                                   input logic [1:0] op);
        if (s != 0 && ((op == 2'b10 && a[31]) || op == 2'b11))
            return 3;
        return 2;
    endfunction

    // Entered and left at 1 time unit after a rising edge.
    task automatic xact(input logic [1:0] v, input int hold);
        logic [1:0]  eg;
        logic [31:0] ed;
        int          id, el, k;
        eg = (v == 2'b11) ? (last_id == 1 ? 2'b01 : 2'b10) : v;
        id = eg[1] ? 1 : 0;
        ed = id ? ref_shift(a1, s1, op1) : ref_shift(a0, s0, op0);
        el = id ? ref_lat(a1, s1, op1) : ref_lat(a0, s0, op0);
        req_valid = v;
        #1;
        chk("grant", {30'd0, req_ready}, {30'd0, eg});
        @(posedge clk);
        #1;
        last_id = id;
        req_valid = 2'b00;
        a0 = ~a0;
        a1 = ~a1;
        s0 = s0 + 5'd7;
        s1 = s1 + 5'd3;
        k = 1;
        while (!rsp_valid && k < 12) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("latency", k, el);
        chk("data", rsp_data, ed);
        chk("id", {31'd0, rsp_id}, id);
        repeat (hold) begin
            req_valid = 2'b11;
            @(posedge clk);
            #1;
            chk("hold_ready", {30'd0, req_ready}, 32'd0);
            chk("hold_data", rsp_data, ed);
            chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("rsp_drop", {31'd0, rsp_valid}, 32'd0);
    endtask

    task automatic setop(input int who, input logic [31:0] a,
                         input logic [4:0] s, input logic [1:0] op);
        if (who == 0) begin
            a0 = a; s0 = s; op0 = op;
        end else begin
            a1 = a; s1 = s; op1 = op;
        end
    endtask

    initial begin
        int          k, seen;
        logic [1:0]  v;
        #1;
        chk("rst_ready", {28'd0, fp_ready, req_ready}, 32'd0);
        req_valid = 2'b11;
        #1;
        chk("rst_ready_v", {30'd0, req_ready}, 32'd0);
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_data", rsp_data, 32'd0);
        chk("rst_id", {31'd0, rsp_id}, 32'd0);
        chk("rst_sha", sh_a, 32'd0);
        chk("rst_shb", sh_b, 32'd0);
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        reset = 1'b1;

        setop(0, 32'h0000_0001, 5'd31, 2'b00);
        xact(2'b01, 0);
        chk("idle_sha", sh_a, 32'd0);
        setop(1, 32'h8000_0000, 5'd4, 2'b10);
        xact(2'b10, 0);
        setop(1, 32'h8000_0000, 5'd4, 2'b01);
        xact(2'b10, 0);
        setop(0, 32'h8000_0001, 5'd1, 2'b11);
        xact(2'b01, 0);
        setop(0, 32'h8000_0001, 5'd0, 2'b11);
        xact(2'b01, 0);
        setop(1, 32'hF000_000F, 5'd0, 2'b10);
        xact(2'b10, 5);

        // Tie-breaking with both requesters held valid.
        reset = 1'b0;
        #1;
        reset = 1'b1;
        setop(0, 32'h0000_0011, 5'd3, 2'b00);
        setop(1, 32'h0000_0101, 5'd3, 2'b00);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            k = 0;
            while (!rsp_valid && k < 12) begin
                @(posedge clk);
                #1;
                k++;
            end
            chk("rr_wait", {31'd0, rsp_valid}, 32'd1);
            chk("rr_id", {31'd0, rsp_id}, n % 2);
            chk("rr_data", rsp_data, (n % 2) ? 32'h808 : 32'h88);
            chk("fp_valid", {31'd0, fp_valid}, 32'd1);
            chk("fp_id", {31'd0, fp_id}, 32'd0);
            chk("fp_data", fp_data, 32'h88);
            @(posedge clk);
            #1;
        end
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        last_id = 1;

        // Reset while the second pass is in flight.
        reset = 1'b0;
        #1;
        reset = 1'b1;
        setop(1, 32'h8000_0000, 5'd4, 2'b10);
        req_valid = 2'b10;
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        chk("pass2_sha", sh_a, 32'hFFFF_FFFF);
        reset = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("mid_ready", {30'd0, req_ready}, 32'd0);
        chk("mid_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_data", rsp_data, 32'd0);
        chk("mid_id", {31'd0, rsp_id}, 32'd0);
        chk("mid_sha", sh_a, 32'd0);
        chk("mid_shb", sh_b, 32'd0);
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        reset = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen++;
        end
        chk("no_ghost_rsp", seen, 0);
        last_id = 1;
        setop(0, 32'h1234_5678, 5'd8, 2'b11);
        xact(2'b01, 0);

        for (int n = 0; n < 30; n++) begin
            setop(0, $urandom, 5'($urandom_range(0, 31)),
                  2'($urandom_range(0, 3)));
            setop(1, $urandom, 5'($urandom_range(0, 31)),
                  2'($urandom_range(0, 3)));
            if ($urandom_range(0, 5) == 0) s0 = 5'd0;
            if ($urandom_range(0, 5) == 0) a1[31] = 1'b1;
            v = 2'($urandom_range(1, 3));
            xact(v, $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
